logic_op_sequencer: RTL

Clocked issuing side of the 32-bit logical units (AND, OR, XOR, NAND, NOR, XNOR, NOT, two's complement). It accepts one operation request over a valid/ready handshake and drives the operand buses that feed the logic units. It releases those buses to high-Z whenever no operation is in flight, holds them for a fixed settle window, then captures the selected unit's result into a registered response with its own valid/ready handshake. It sits between the ALU decode stage and the result writeback path.

---
 rtl/logic_op_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/logic_op_sequencer.sv
// rtl/logic_op_sequencer.sv - issue/settle/capture sequencer for the 32-bit logic units
module logic_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output wire  [WIDTH-1:0]   opa,
    output wire  [WIDTH-1:0]   opb,
    input  logic [8*WIDTH-1:0] res_vec,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [2:0]         rsp_op,
    output logic               rsp_zero
);
    localparam int         SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_EFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [WIDTH-1:0] unit_res;
    logic             drive_a;
    logic             drive_b;

    always_comb begin
        unit_res = '0;
        for (int k = 0; k < 8; k++) begin
            if (op_q == 3'(k)) begin
                unit_res = res_vec[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    cnt_d   = SETTLE_LD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - 4'd1;
                // Capture on the last settle edge; <= guards a counter that somehow reached 0.
                if (cnt_q <= 4'd1) begin
                    cnt_d       = 4'd0;
                    rsp_data_d  = unit_res;
                    rsp_op_d    = op_q;
                    rsp_zero_d  = (unit_res == '0);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= 3'd0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // Bus enables come only from the state register so the buses move on clock edges alone.
    assign drive_a = (state_q == DRIVE);
    assign drive_b = drive_a && !(op_q[2] && op_q[1]);

    assign opa = drive_a ? a_q : {WIDTH{1'bz}};
    assign opb = drive_b ? b_q : {WIDTH{1'bz}};

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_zero  = rsp_zero_q;
endmodule
